funrv32_wb_stage: RTL and testbench
===================================

// Module: funrv32_wb_stage
// PURPOSE
//  Writeback stage of the funRV32 core; sits directly upstream of regfile and drives its write port
//  (we/ad/rd). Accepts completed ALU results and load requests from execute; for loads, waits on the
//  data-memory response, aligns and sign/zero-extends, then writes. Mirrors every write on a bypass
//  port for decode forwarding, and counts retired writebacks.
// PARAMETERS
//  LOAD_TIMEOUT  16  max cycles in WAIT_LOAD before abort (>=2)
//  CNT_W         32  width of retired_count
// PORTS
//  clk            in   1      rising-edge clock
//  reset          in   1      synchronous, active-high reset
//  ex_valid       in   1      execute presents an op
//  ex_ready       out  1      stage can accept; ex_ready = (state==IDLE), combinational
//  ex_rd_addr     in   5      destination register
//  ex_result      in   32     ALU result (ignored for loads)
//  ex_is_load     in   1      op is a load
//  ex_load_fmt    in   3      RV32 funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
//  ex_addr_lo     in   2      byte address bits [1:0] of the load
//  mem_rvalid     in   1      load data valid (single-cycle pulse)
//  mem_rdata      in   32     load word, little-endian lanes
//  rf_we          out  1      regfile write enable (registered)
//  rf_ad          out  5      regfile write address (registered)
//  rf_rd          out  32     regfile write data (registered)
//  byp_valid/byp_addr/byp_data out 1/5/32  identical copies of rf_we/rf_ad/rf_rd
//  retired_count  out  CNT_W  count of writes issued with rf_we=1
//  err_load       out  1      sticky: misaligned or illegal-format load
//  err_timeout    out  1      sticky: load response not seen within LOAD_TIMEOUT
// BEHAVIOUR
//  Reset: state=IDLE, rf_we=0, rf_ad=0, rf_rd=0, retired_count=0, err_load=0, err_timeout=0,
//   timer=0, captured load info cleared. Reset mid-WAIT_LOAD aborts the load; no write.
//  Accept = ex_valid & ex_ready. States: IDLE, WAIT_LOAD.
//  IDLE, accept, !ex_is_load: next cycle rf_we=1, rf_ad=ex_rd_addr, rf_rd=ex_result (latency 1).
//   Back-to-back ALU ops accepted every cycle -> one write per cycle.
//  IDLE, accept, ex_is_load, legal+aligned: capture rd_addr/fmt/addr_lo, go WAIT_LOAD, timer=0.
//   Next cycle rf_we=0.
//  Legal alignment: LB/LBU any addr_lo; LH/LHU addr_lo in {0,2}; LW addr_lo==0.
//  Illegal fmt (011,110,111) or misaligned: accepted, stay IDLE, set err_load, no write, no count.
//  WAIT_LOAD: ex_ready=0. On mem_rvalid: lane = mem_rdata >> (8*addr_lo);
//   LB sext lane[7:0], LBU zext lane[7:0], LH sext lane[15:0], LHU zext lane[15:0], LW full word.
//   Next cycle rf_we=1 with that data; state->IDLE same edge (ex_ready high the cycle rf_we=1).
//  Timeout: timer increments each WAIT_LOAD cycle without mem_rvalid; when timer reaches
//   LOAD_TIMEOUT-1 with no mem_rvalid: set err_timeout, ->IDLE, no write. mem_rvalid on that same
//   cycle wins (normal write, no error).
//  mem_rvalid in IDLE: ignored, no write, no error.
//  rd_addr==0: op/load completes normally but rf_we forced 0 and retired_count not incremented.
//  rf_we=1 only for exactly one cycle per write; otherwise rf_we=0, rf_ad/rf_rd hold last value.
//  retired_count += 1 on each cycle rf_we becomes 1; wraps modulo 2^CNT_W.
//  err_* sticky until reset; they do not stall the stage.
// TESTING
//  Reset then 3 ALU ops rd=1,2,3 res=0xA,0xB,0xC back-to-back -> rf_we 3 consecutive cycles,
//   rf_ad 1,2,3, rf_rd 0xA,0xB,0xC, retired_count=3, byp_* identical.
//  LB rd=5 addr_lo=3, mem_rdata=0x80FF_0000 after 4 cycles -> ex_ready low 4 cycles, then rf_we=1,
//   rf_rd=0xFFFF_FF80; LBU same -> 0x0000_0080; LHU addr_lo=2, 0x8001_1234 -> 0x0000_8001.
//  LW addr_lo=1 -> err_load=1, no write, state IDLE, next ALU op accepted same cycle after.
//  Load with no response, LOAD_TIMEOUT=16 -> err_timeout=1 after 16 WAIT_LOAD cycles, no write;
//   repeat with mem_rvalid exactly on cycle 16 -> normal write, err_timeout=0.
//  ALU op rd=0 res=0x55 and LW rd=0 -> rf_we never 1, retired_count unchanged.
//  Assert reset while in WAIT_LOAD, then pulse mem_rvalid -> no write, all outputs at reset values.

Source files
------------

// File: rtl/funrv32_wb_stage.sv
// funRV32 writeback stage: retires ALU results and aligned loads into the
// regfile write port, mirrors each write on the bypass port, counts retirements.
module funrv32_wb_stage #(
    parameter int LOAD_TIMEOUT = 16,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_valid,
    output logic             ex_ready,
    input  logic [4:0]       ex_rd_addr,
    input  logic [31:0]      ex_result,
    input  logic             ex_is_load,
    input  logic [2:0]       ex_load_fmt,
    input  logic [1:0]       ex_addr_lo,
    input  logic             mem_rvalid,
    input  logic [31:0]      mem_rdata,
    output logic             rf_we,
    output logic [4:0]       rf_ad,
    output logic [31:0]      rf_rd,
    output logic             byp_valid,
    output logic [4:0]       byp_addr,
    output logic [31:0]      byp_data,
    output logic [CNT_W-1:0] retired_count,
    output logic             err_load,
    output logic             err_timeout
);

    typedef enum logic [0:0] {
        IDLE,
        WAIT_LOAD
    } state_t;

    localparam int TW = (LOAD_TIMEOUT > 2) ? $clog2(LOAD_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMAX = TW'(LOAD_TIMEOUT - 1);

    state_t      state;
    logic [TW-1:0] timer;
    logic [4:0]  ld_rd;
    logic [2:0]  ld_fmt;
    logic [1:0]  ld_lo;

    logic        legal;
    logic [31:0] lane;
    logic [31:0] ld_data;

    assign ex_ready = (state == IDLE);

    always_comb begin
        legal = 1'b0;
        unique case (ex_load_fmt)
            3'b000, 3'b100: legal = 1'b1;
            3'b001, 3'b101: legal = ~ex_addr_lo[0];
            3'b010:         legal = (ex_addr_lo == 2'b00);
            default:        legal = 1'b0;
        endcase
    end

    // Shift the addressed byte lane down to bit 0, then extend by format.
    assign lane = mem_rdata >> {ld_lo, 3'b000};

    always_comb begin
        ld_data = lane;
        unique case (1'b1)
            ld_fmt == 3'b000: ld_data = {{24{lane[7]}}, lane[7:0]};
            ld_fmt == 3'b100: ld_data = {24'd0, lane[7:0]};
            ld_fmt == 3'b001: ld_data = {{16{lane[15]}}, lane[15:0]};
            ld_fmt == 3'b101: ld_data = {16'd0, lane[15:0]};
            default:          ld_data = lane;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            timer         <= '0;
            ld_rd         <= '0;
            ld_fmt        <= '0;
            ld_lo         <= '0;
            rf_we         <= 1'b0;
            rf_ad         <= '0;
            rf_rd         <= '0;
            retired_count <= '0;
            err_load      <= 1'b0;
            err_timeout   <= 1'b0;
        end else begin
            rf_we <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (ex_valid) begin
                        if (!ex_is_load) begin
                            if (ex_rd_addr != 5'd0) begin
                                rf_we         <= 1'b1;
                                rf_ad         <= ex_rd_addr;
                                rf_rd         <= ex_result;
                                retired_count <= retired_count + CNT_W'(1);
                            end
                        end else if (legal) begin
                            state  <= WAIT_LOAD;
                            timer  <= '0;
                            ld_rd  <= ex_rd_addr;
                            ld_fmt <= ex_load_fmt;
                            ld_lo  <= ex_addr_lo;
                        end else begin
                            err_load <= 1'b1;
                        end
                    end
                end
                WAIT_LOAD: begin
                    // A response on the final allowed cycle still wins.
                    if (mem_rvalid) begin
                        state <= IDLE;
                        timer <= '0;
                        if (ld_rd != 5'd0) begin
                            rf_we         <= 1'b1;
                            rf_ad         <= ld_rd;
                            rf_rd         <= ld_data;
                            retired_count <= retired_count + CNT_W'(1);
                        end
                    end else if (timer == TMAX) begin
                        state       <= IDLE;
                        timer       <= '0;
                        err_timeout <= 1'b1;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign byp_valid = rf_we;
    assign byp_addr  = rf_ad;
    assign byp_data  = rf_rd;

endmodule

// File: tb/tb_funrv32_wb_stage.sv
// Bench for funrv32_wb_stage: directed table, corner sequences, and
// randomized traffic against a transaction-level reference model.
module tb_funrv32_wb_stage;

    localparam int LT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic        ex_ready;
    logic [4:0]  ex_rd_addr;
    logic [31:0] ex_result;
    logic        ex_is_load;
    logic [2:0]  ex_load_fmt;
    logic [1:0]  ex_addr_lo;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rf_we;
    logic [4:0]  rf_ad;
    logic [31:0] rf_rd;
    logic        byp_valid;
    logic [4:0]  byp_addr;
    logic [31:0] byp_data;
    logic [31:0] retired_count;
    logic        err_load;
    logic        err_timeout;

    funrv32_wb_stage #(
        .LOAD_TIMEOUT(LT),
        .CNT_W(32)
    ) dut (
        .clk(clk),
        .reset(reset),
        .ex_valid(ex_valid),
        .ex_ready(ex_ready),
        .ex_rd_addr(ex_rd_addr),
        .ex_result(ex_result),
        .ex_is_load(ex_is_load),
        .ex_load_fmt(ex_load_fmt),
        .ex_addr_lo(ex_addr_lo),
        .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata),
        .rf_we(rf_we),
        .rf_ad(rf_ad),
        .rf_rd(rf_rd),
        .byp_valid(byp_valid),
        .byp_addr(byp_addr),
        .byp_data(byp_data),
        .retired_count(retired_count),
        .err_load(err_load),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state
    bit          m_wait;
    int          m_cnt;
    logic [4:0]  m_rd;
    logic [2:0]  m_fmt;
    logic [1:0]  m_lo;
    logic        e_we;
    logic [4:0]  e_ad;
    logic [31:0] e_rd;
    logic [31:0] e_cnt;
    logic        e_el;
    logic        e_et;

    typedef struct {
        logic        v;
        logic        ld;
        logic [4:0]  rd;
        logic [31:0] res;
        logic [2:0]  fmt;
        logic [1:0]  lo;
        logic        rv;
        logic [31:0] rdata;
        logic        rdy;
        logic        we;
        logic [4:0]  ad;
        logic [31:0] d;
    } vec_t;

    vec_t tbl[18];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    function automatic bit load_ok(input logic [2:0] fmt, input logic [1:0] lo);
        int sz;
        case (fmt)
            3'b000, 3'b100: sz = 1;
            3'b001, 3'b101: sz = 2;
            3'b010:         sz = 4;
            default:        return 1'b0;
        endcase
        return (int'(lo) % sz) == 0;
    endfunction

    function automatic logic [31:0] extend(input logic [2:0] fmt,
                                           input logic [1:0] lo,
                                           input logic [31:0] w);
        longint bits;
        longint v;
        bits = (fmt[1:0] == 2'b00) ? 8 : (fmt[1:0] == 2'b01) ? 16 : 32;
        v = longint'(w) >> (8 * int'(lo));
        if (bits < 32) begin
            v = v % (longint'(1) << bits);
            if (!fmt[2] && v >= (longint'(1) << (bits - 1)))
                v = v - (longint'(1) << bits);
        end
        return v[31:0];
    endfunction

    function automatic void put(input logic [4:0] rd, input logic [31:0] d);
        if (rd != 5'd0) begin
            e_we  = 1'b1;
            e_ad  = rd;
            e_rd  = d;
            e_cnt = e_cnt + 32'd1;
        end
    endfunction

    function automatic void model_step();
        if (reset) begin
            m_wait = 1'b0;
            m_cnt  = 0;
            e_we   = 1'b0;
            e_ad   = '0;
            e_rd   = '0;
            e_cnt  = '0;
            e_el   = 1'b0;
            e_et   = 1'b0;
            return;
        end
        e_we = 1'b0;
        if (!m_wait) begin
            if (ex_valid) begin
                if (!ex_is_load) begin
                    put(ex_rd_addr, ex_result);
                end else if (load_ok(ex_load_fmt, ex_addr_lo)) begin
                    m_wait = 1'b1;
                    m_cnt  = 0;
                    m_rd   = ex_rd_addr;
                    m_fmt  = ex_load_fmt;
                    m_lo   = ex_addr_lo;
                end else begin
                    e_el = 1'b1;
                end
            end
        end else begin
            m_cnt++;
            if (mem_rvalid) begin
                m_wait = 1'b0;
                put(m_rd, extend(m_fmt, m_lo, mem_rdata));
            end else if (m_cnt == LT) begin
                m_wait = 1'b0;
                e_et   = 1'b1;
            end
        end
    endfunction

    task automatic check_outs();
        check("rf_we", 32'(rf_we), 32'(e_we));
        check("rf_ad", 32'(rf_ad), 32'(e_ad));
        check("rf_rd", rf_rd, e_rd);
        check("byp_valid", 32'(byp_valid), 32'(e_we));
        check("byp_addr", 32'(byp_addr), 32'(e_ad));
        check("byp_data", byp_data, e_rd);
        check("retired_count", retired_count, e_cnt);
        check("err_load", 32'(err_load), 32'(e_el));
        check("err_timeout", 32'(err_timeout), 32'(e_et));
    endtask

    task automatic clock();
        model_step();
        @(posedge clk);
        #1;
        check_outs();
    endtask

    task automatic cycle();
        check("ex_ready", 32'(ex_ready), 32'(!m_wait));
        clock();
    endtask

    task automatic set_idle();
        ex_valid   = 1'b0;
        ex_is_load = 1'b0;
        ex_rd_addr = '0;
        ex_result  = '0;
        ex_load_fmt = '0;
        ex_addr_lo = '0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
    endtask

    task automatic set_load(input logic [4:0] rd, input logic [2:0] fmt,
                            input logic [1:0] lo);
        set_idle();
        ex_valid    = 1'b1;
        ex_is_load  = 1'b1;
        ex_rd_addr  = rd;
        ex_load_fmt = fmt;
        ex_addr_lo  = lo;
    endtask

    task automatic do_reset();
        set_idle();
        reset = 1'b1;
        clock();
        reset = 1'b0;
    endtask

    function automatic vec_t mk(input int v, input int ld, input int rd,
                                input int res, input int fmt, input int lo,
                                input int rv, input int rdata, input int rdy,
                                input int we, input int ad, input int d);
        vec_t r;
        r.v = 1'(v);     r.ld = 1'(ld);   r.rd = 5'(rd);
        r.res = 32'(res); r.fmt = 3'(fmt); r.lo = 2'(lo);
        r.rv = 1'(rv);   r.rdata = 32'(rdata);
        r.rdy = 1'(rdy); r.we = 1'(we);   r.ad = 5'(ad); r.d = 32'(d);
        return r;
    endfunction

    initial begin
        tbl[0]  = mk(1, 0, 1, 'hA, 0, 0, 0, 0, 1, 1, 1, 'hA);
        tbl[1]  = mk(1, 0, 2, 'hB, 0, 0, 0, 0, 1, 1, 2, 'hB);
        tbl[2]  = mk(1, 0, 3, 'hC, 0, 0, 0, 0, 1, 1, 3, 'hC);
        tbl[3]  = mk(1, 1, 5, 0, 'b000, 3, 0, 0, 1, 0, 3, 'hC);
        tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 'hC);
        tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 'hC);
        tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 'hC);
        tbl[7]  = mk(0, 0, 0, 0, 0, 0, 1, 'h80FF0000, 0, 1, 5, 'hFFFFFF80);
        tbl[8]  = mk(1, 1, 5, 0, 'b100, 3, 0, 0, 1, 0, 5, 'hFFFFFF80);
        tbl[9]  = mk(0, 0, 0, 0, 0, 0, 1, 'h80FF0000, 0, 1, 5, 'h80);
        tbl[10] = mk(1, 1, 6, 0, 'b101, 2, 0, 0, 1, 0, 5, 'h80);
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 1, 'h80011234, 0, 1, 6, 'h8001);
        tbl[12] = mk(1, 1, 7, 0, 'b010, 1, 0, 0, 1, 0, 6, 'h8001);
        tbl[13] = mk(1, 0, 8, 'h99, 0, 0, 0, 0, 1, 1, 8, 'h99);
        tbl[14] = mk(1, 0, 0, 'h55, 0, 0, 0, 0, 1, 0, 8, 'h99);
        tbl[15] = mk(1, 1, 0, 0, 'b010, 0, 0, 0, 1, 0, 8, 'h99);
        tbl[16] = mk(0, 0, 0, 0, 0, 0, 1, 'h12345678, 0, 0, 8, 'h99);
        tbl[17] = mk(0, 0, 0, 0, 0, 0, 1, 'hDEADBEEF, 1, 0, 8, 'h99);

        set_idle();
        m_wait = 1'b0;
        m_cnt  = 0;
        do_reset();
        check("reset ex_ready", 32'(ex_ready), 32'd1);
        check("reset count", retired_count, 32'd0);

        foreach (tbl[i]) begin
            ex_valid    = tbl[i].v;
            ex_is_load  = tbl[i].ld;
            ex_rd_addr  = tbl[i].rd;
            ex_result   = tbl[i].res;
            ex_load_fmt = tbl[i].fmt;
            ex_addr_lo  = tbl[i].lo;
            mem_rvalid  = tbl[i].rv;
            mem_rdata   = tbl[i].rdata;
            check($sformatf("t%0d ready", i), 32'(ex_ready), 32'(tbl[i].rdy));
            clock();
            check($sformatf("t%0d we", i), 32'(rf_we), 32'(tbl[i].we));
            check($sformatf("t%0d ad", i), 32'(rf_ad), 32'(tbl[i].ad));
            check($sformatf("t%0d data", i), rf_rd, tbl[i].d);
        end
        set_idle();
        check("table count", retired_count, 32'd7);
        check("table err_load", 32'(err_load), 32'd1);
        check("table err_timeout", 32'(err_timeout), 32'd0);

        // Response on the last allowed wait cycle still writes.
        do_reset();
        set_load(5'd9, 3'b010, 2'd0);
        cycle();
        set_idle();
        repeat (LT - 1) cycle();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFEF00D;
        cycle();
        set_idle();
        check("edge we", 32'(rf_we), 32'd1);
        check("edge data", rf_rd, 32'hCAFEF00D);
        check("edge err_timeout", 32'(err_timeout), 32'd0);

        // No response at all: abort after LT wait cycles.
        set_load(5'd10, 3'b000, 2'd1);
        cycle();
        set_idle();
        repeat (LT - 1) cycle();
        check("to pending", 32'(err_timeout), 32'd0);
        check("to busy", 32'(ex_ready), 32'd0);
        cycle();
        check("to err", 32'(err_timeout), 32'd1);
        check("to no write", 32'(rf_we), 32'd0);
        check("to ready", 32'(ex_ready), 32'd1);

        // Reset mid-load drops the pending load.
        set_load(5'd11, 3'b010, 2'd0);
        cycle();
        set_idle();
        repeat (3) cycle();
        do_reset();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h11111111;
        cycle();
        set_idle();
        check("rst we", 32'(rf_we), 32'd0);
        check("rst count", retired_count, 32'd0);
        check("rst rd", rf_rd, 32'd0);
        check("rst ready", 32'(ex_ready), 32'd1);

        for (int n = 0; n < 3000; n++) begin
            ex_valid    = ($urandom_range(0, 1) == 1);
            ex_is_load  = ($urandom_range(0, 9) < 4);
            ex_rd_addr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            ex_result   = $urandom;
            ex_load_fmt = 3'($urandom);
            ex_addr_lo  = 2'($urandom);
            mem_rvalid  = ($urandom_range(0, 99) < 15);
            mem_rdata   = $urandom;
            if ($urandom_range(0, 199) == 0) begin
                reset = 1'b1;
                clock();
                reset = 1'b0;
            end else begin
                cycle();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
